gcn_phase_scheduler: RTL and testbench

//  Top-level sequencer for one GCN layer pass. On start, walks every weight column through a

---
 rtl/gcn_pkg.sv | 13 +
 rtl/gcn_index_counter.sv | 24 ++
 rtl/gcn_phase_scheduler.sv | 91 +++++++++
 tb/tb_gcn_phase_scheduler.sv | 133 +++++++++++++
 4 files changed

// File: rtl/gcn_pkg.sv
// gcn_pkg: shared phase encoding and default layer dimensions for the GCN scheduler
package gcn_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_W    = 3'd1,
        COMPUTE   = 3'd2,
        AGGREGATE = 3'd3,
        DONE      = 3'd4
    } phase_e;
    localparam int FEATURE_ROWS    = 6;
    localparam int WEIGHT_COLS     = 3;
    localparam int COO_NUM_OF_COLS = 6;
endpackage

// File: rtl/gcn_index_counter.sv
// gcn_index_counter: wrapping index counter 0..MAX-1 with last flag
// Ports: clk, rst_n (async active-low clear), clr_i (sync clear), en_i (advance),
//        cnt_o (current index), last_o (index == MAX-1)
module gcn_index_counter #(
    parameter int MAX = 2,
    parameter int BW  = $clog2(MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [BW-1:0] cnt_o,
    output logic          last_o
);
    logic [BW-1:0] cnt_q;
    assign cnt_o  = cnt_q;
    assign last_o = cnt_q == BW'(MAX - 1);
    // wrap explicitly at MAX-1 so non-power-of-two ranges never overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i)  cnt_q <= last_o ? '0 : cnt_q + BW'(1);
    end
endmodule

// File: rtl/gcn_phase_scheduler.sv
// gcn_phase_scheduler: phase FSM sequencing weight load, FM x W compute and COO aggregation
// Ports: clk, reset (async active-low), start (level request)
//        busy/done status; weight, feature and COO read strobes with addresses;
//        FM_WM product write strobe with row/col address (one cycle behind each feature read)
module gcn_phase_scheduler #(
    parameter int FEATURE_ROWS    = gcn_pkg::FEATURE_ROWS,
    parameter int WEIGHT_COLS     = gcn_pkg::WEIGHT_COLS,
    parameter int COO_NUM_OF_COLS = gcn_pkg::COO_NUM_OF_COLS,
    parameter int FR_BW  = $clog2(FEATURE_ROWS),
    parameter int WC_BW  = $clog2(WEIGHT_COLS),
    parameter int COO_BW = $clog2(COO_NUM_OF_COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              enable_read_weight,
    output logic [WC_BW-1:0]  read_weight_address,
    output logic              enable_read_feature,
    output logic [FR_BW-1:0]  read_feature_address,
    output logic              enable_write_fm_wm_prod,
    output logic [FR_BW-1:0]  fm_wm_row_address,
    output logic [WC_BW-1:0]  fm_wm_col_address,
    output logic              enable_read_coo,
    output logic [COO_BW-1:0] coo_address
);
    import gcn_pkg::*;
    phase_e state_q, state_d;
    logic [FR_BW-1:0]  row;
    logic [WC_BW-1:0]  col;
    logic [COO_BW-1:0] edge_idx;
    logic row_last, col_last, edge_last;
    logic wr_en_q;
    logic [FR_BW-1:0] wr_row_q;
    logic [WC_BW-1:0] wr_col_q;
    wire idle    = state_q == IDLE;
    wire load_w  = state_q == LOAD_W;
    wire compute = state_q == COMPUTE;
    wire aggr    = state_q == AGGREGATE;
    gcn_index_counter #(.MAX(FEATURE_ROWS), .BW(FR_BW)) u_row (
        .clk(clk), .rst_n(reset), .clr_i(idle), .en_i(compute),
        .cnt_o(row), .last_o(row_last)
    );
    gcn_index_counter #(.MAX(WEIGHT_COLS), .BW(WC_BW)) u_col (
        .clk(clk), .rst_n(reset), .clr_i(idle), .en_i(compute && row_last),
        .cnt_o(col), .last_o(col_last)
    );
    gcn_index_counter #(.MAX(COO_NUM_OF_COLS), .BW(COO_BW)) u_edge (
        .clk(clk), .rst_n(reset), .clr_i(idle), .en_i(aggr),
        .cnt_o(edge_idx), .last_o(edge_last)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = start ? LOAD_W : IDLE;
            LOAD_W:    state_d = COMPUTE;
            COMPUTE:   state_d = !row_last ? COMPUTE : col_last ? AGGREGATE : LOAD_W;
            AGGREGATE: state_d = edge_last ? DONE : AGGREGATE;
            DONE:      state_d = start ? DONE : IDLE;
            default:   state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end
    // product write trails its feature read by one cycle, regardless of the phase it lands in
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q  <= 1'b0;
            wr_row_q <= '0;
            wr_col_q <= '0;
        end else begin
            wr_en_q  <= compute;
            wr_row_q <= compute ? row : '0;
            wr_col_q <= compute ? col : '0;
        end
    end
    assign busy                    = load_w || compute || aggr;
    assign done                    = state_q == DONE;
    assign enable_read_weight      = load_w;
    assign read_weight_address     = load_w ? col : '0;
    assign enable_read_feature     = compute;
    assign read_feature_address    = compute ? row : '0;
    assign enable_write_fm_wm_prod = wr_en_q;
    assign fm_wm_row_address       = wr_row_q;
    assign fm_wm_col_address       = wr_col_q;
    assign enable_read_coo         = aggr;
    assign coo_address             = aggr ? edge_idx : '0;
endmodule

// File: tb/tb_gcn_phase_scheduler.sv
// tb_gcn_phase_scheduler: scoreboard bench for the GCN phase scheduler at default dimensions
module tb_gcn_phase_scheduler;
    typedef struct packed {
        logic       busy;
        logic       rwe;
        logic [1:0] rwa;
        logic       rfe;
        logic [2:0] rfa;
        logic       wwe;
        logic [2:0] wr;
        logic [1:0] wc;
        logic       ce;
        logic [2:0] ca;
    } rec_t;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic busy, done, enable_read_weight, enable_read_feature, enable_write_fm_wm_prod, enable_read_coo;
    logic [1:0] read_weight_address, fm_wm_col_address;
    logic [2:0] read_feature_address, fm_wm_row_address, coo_address;
    rec_t q[$];
    int checks = 0, errors = 0, writes = 0, cyc;
    gcn_phase_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .enable_read_weight(enable_read_weight), .read_weight_address(read_weight_address),
        .enable_read_feature(enable_read_feature), .read_feature_address(read_feature_address),
        .enable_write_fm_wm_prod(enable_write_fm_wm_prod), .fm_wm_row_address(fm_wm_row_address),
        .fm_wm_col_address(fm_wm_col_address), .enable_read_coo(enable_read_coo),
        .coo_address(coo_address)
    );
    always #5 clk = ~clk;
    function automatic rec_t act();
        return {busy, enable_read_weight, read_weight_address, enable_read_feature,
                read_feature_address, enable_write_fm_wm_prod, fm_wm_row_address,
                fm_wm_col_address, enable_read_coo, coo_address};
    endfunction
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
        end
    endtask
    task automatic idle_chk(input string n);
        chk(n, {11'd0, act(), done}, 32'd0);
    endtask
    // expected per-busy-cycle outputs of one pass at 6 rows x 3 cols x 6 edges
    task automatic push_pass();
        rec_t r;
        logic pe = 1'b0;
        logic [2:0] pr = '0;
        logic [1:0] pc = '0;
        for (int c = 0; c < 3; c++) begin
            r = '0; r.busy = 1'b1; r.rwe = 1'b1; r.rwa = 2'(c);
            r.wwe = pe; r.wr = pr; r.wc = pc;
            q.push_back(r);
            pe = 1'b0; pr = '0; pc = '0;
            for (int rr = 0; rr < 6; rr++) begin
                r = '0; r.busy = 1'b1; r.rfe = 1'b1; r.rfa = 3'(rr);
                r.wwe = pe; r.wr = pr; r.wc = pc;
                q.push_back(r);
                pe = 1'b1; pr = 3'(rr); pc = 2'(c);
            end
        end
        for (int e = 0; e < 6; e++) begin
            r = '0; r.busy = 1'b1; r.ce = 1'b1; r.ca = 3'(e);
            r.wwe = pe; r.wr = pr; r.wc = pc;
            q.push_back(r);
            pe = 1'b0; pr = '0; pc = '0;
        end
    endtask
    always @(negedge clk) begin
        if (reset && (busy || enable_write_fm_wm_prod)) begin
            writes += int'(enable_write_fm_wm_prod);
            if (q.size() == 0) chk("sb_unexpected", {12'd0, act()}, 32'd0);
            else chk("sb", {12'd0, act()}, {12'd0, q.pop_front()});
        end
    end
    task automatic run_pass(input bit hold, input bit toggle);
        @(negedge clk);
        push_pass();
        writes = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = hold;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (toggle) start = (cyc >= 3 && cyc <= 15) ? cyc[0] : 1'b0;
            if (done) break;
        end
        chk("latency", cyc, 27);
        chk("done", {done, busy}, 2'b10);
        chk("q_empty", q.size(), 0);
        chk("writes", writes, 18);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        idle_chk("in_reset");
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle_chk("idle");
        end
        run_pass(1'b0, 1'b0);
        @(posedge clk); #1 chk("done_drop", {done, busy}, 2'b00);
        run_pass(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 chk("done_hold", {done, busy}, 2'b10);
        end
        start = 1'b0;
        @(posedge clk); #1 chk("hold_release", {done, busy}, 2'b00);
        run_pass(1'b0, 1'b1);
        @(posedge clk); #1 chk("toggle_drop", {done, busy}, 2'b00);
        @(negedge clk);
        push_pass();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #1 chk("pre_rst_row", {enable_read_feature, read_feature_address}, {1'b1, 3'd3});
        reset = 1'b0;
        #1 idle_chk("async_rst");
        q.delete();
        repeat (2) @(negedge clk);
        idle_chk("rst_hold");
        reset = 1'b1;
        run_pass(1'b0, 1'b0);
        @(posedge clk); #1 chk("post_rst_drop", {done, busy}, 2'b00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
